mem_arbiter: RTL

- Sits directly downstream of the I-cache and D-cache fill FSMs, between them and the single-port pipelined main memory (4-cycle read latency, one access per cycle).
- Arbitrates three requesters: I-fill, D-fill and D-cache write-through stores.
- Generates the 8 sequential word addresses of each block fill itself and routes returning data-valid pulses to the owning fill FSM.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_addr_gen.sv | 38 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache-fill / write-through memory arbiter.
// Holds the state encoding, block geometry and fill-source tags.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_IFILL = 3'd2,
    ST_DFILL = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  typedef enum logic {
    FILL_I = 1'b0,
    FILL_D = 1'b1
  } fill_src_t;

  localparam int BLOCK_WORDS = 8;
  // Byte-offset bits inside a 16-byte block; cleared to form the fill base.
  localparam int BLK_OFF_W   = 4;

endpackage

// File: rtl/mem_arb_addr_gen.sv
// Block-fill address generator: latches the block base on grant and steps
// through the word addresses of the block, one per issued read.
module mem_arb_addr_gen #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = mem_arbiter_pkg::BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              issue,
  output logic              issue_done,
  output logic [ADDR_W-1:0] fill_addr
);
  import mem_arbiter_pkg::*;

  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      issue_cnt <= '0;
    end else if (load) begin
      base      <= {load_addr[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
      issue_cnt <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

  assign issue_done = (issue_cnt == CNT_W'(BLOCK_WORDS));
  // Word offsets are 2 bytes apart.
  assign fill_addr  = base + {{(ADDR_W-CNT_W-1){1'b0}}, issue_cnt, 1'b0};

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between I-fill, D-fill and write-through stores in front of a
// single-port pipelined memory; issues block-fill reads and routes returns.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = mem_arbiter_pkg::BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill_req,
  input  logic [ADDR_W-1:0] i_fill_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_fill_req,
  input  logic [ADDR_W-1:0] d_fill_addr,
  output logic              d_grant,
  output logic              d_data_valid,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] fill_data,
  output logic              arb_busy,
  output logic              protocol_err
);
  import mem_arbiter_pkg::*;

  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

  arb_state_t        state;
  arb_state_t        next_grant;
  fill_src_t         last_fill;
  logic [CNT_W-1:0]  ret_cnt;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] fill_addr;
  logic              grant_load;
  logic              fill_active;
  logic              issue;
  logic              issue_done;
  logic              perr_q;

  // Stores win outright; between two fills the one not served last wins.
  always_comb begin
    next_grant = ST_IDLE;
    load_addr  = d_wr_addr;
    if (d_wr_req) begin
      next_grant = ST_WRITE;
      load_addr  = d_wr_addr;
    end else if (i_fill_req && (!d_fill_req || last_fill == FILL_D)) begin
      next_grant = ST_IFILL;
      load_addr  = i_fill_addr;
    end else if (d_fill_req) begin
      next_grant = ST_DFILL;
      load_addr  = d_fill_addr;
    end
  end

  assign grant_load  = (state == ST_IDLE) && (next_grant != ST_IDLE);
  assign fill_active = (state == ST_IFILL) || (state == ST_DFILL);
  assign issue       = fill_active && !issue_done;

  mem_arb_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (grant_load),
    .load_addr  (load_addr),
    .issue      (issue),
    .issue_done (issue_done),
    .fill_addr  (fill_addr)
  );

  // A fill ends on its last return, not its last issue: reads cannot be cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_fill <= FILL_I;
      ret_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= next_grant;
          ret_cnt <= '0;
        end
        ST_WRITE: state <= ST_IDLE;
        ST_IFILL, ST_DFILL: begin
          if (mem_data_valid) begin
            ret_cnt <= ret_cnt + CNT_W'(1);
            if (ret_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
              state     <= ST_DONE;
              last_fill <= (state == ST_IFILL) ? FILL_I : FILL_D;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && d_wr_req) begin
      wr_addr_q <= d_wr_addr;
      wr_data_q <= d_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      perr_q <= 1'b0;
    else if (mem_data_valid && !fill_active)
      perr_q <= 1'b1;
  end

  assign i_grant      = (state == ST_IFILL);
  assign d_grant      = (state == ST_DFILL);
  assign i_data_valid = (state == ST_IFILL) && mem_data_valid;
  assign d_data_valid = (state == ST_DFILL) && mem_data_valid;
  assign d_wr_ack     = (state == ST_WRITE);
  assign mem_enable   = (state == ST_WRITE) || issue;
  assign mem_wr       = (state == ST_WRITE);
  assign mem_addr     = (state == ST_WRITE) ? wr_addr_q : (issue ? fill_addr : '0);
  assign mem_data_in  = (state == ST_WRITE) ? wr_data_q : '0;
  assign fill_data    = mem_data_out;
  assign arb_busy     = (state != ST_IDLE);
  assign protocol_err = perr_q;

endmodule
